// File: rtl/axis_out.sv
// ---------------------------------------------------------------------------
// axis_out -- FIR output stage.
//
// Takes result samples from the FIR dataflow core over a valid/ready pair,
// holds them in a small circular FIFO, and sends them out as an AXI-Stream
// master. It counts samples against the programmed transfer length, raises
// tlast on the final sample, and pulses ap_done once that sample has been
// taken downstream.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// when valid and ready are both high in that cycle. The producer holds valid
// and data stable until that happens. Neither ready here depends
// combinationally on the partner's valid.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          asynchronous, active-high reset
//   ap_start     one-cycle start pulse (ignored outside IDLE)
//   data_length  samples in the transfer, captured on an accepted ap_start
//   fir_data     FIR result sample
//   fir_valid    fir_data is valid
//   fir_ready    block accepts fir_data this cycle
//   sm_tdata     AXI-Stream master data (0 while the FIFO is empty)
//   sm_tvalid    AXI-Stream master valid
//   sm_tlast     final sample of the transfer
//   sm_tready    downstream ready
//   ap_done      one-cycle pulse when the transfer completes
//   out_busy     high whenever the state machine is not IDLE
// ---------------------------------------------------------------------------
module axis_out #(
    parameter int pDATA_WIDTH = 32,
    parameter int pLEN_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ap_start,
    input  logic [pLEN_WIDTH-1:0]  data_length,
    input  logic [pDATA_WIDTH-1:0] fir_data,
    input  logic                   fir_valid,
    output logic                   fir_ready,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tvalid,
    output logic                   sm_tlast,
    input  logic                   sm_tready,
    output logic                   ap_done,
    output logic                   out_busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [pLEN_WIDTH-1:0] LEN_ONE = pLEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [pLEN_WIDTH-1:0]   len;
    logic [pLEN_WIDTH-1:0]   in_cnt;
    logic [pLEN_WIDTH-1:0]   out_cnt;

    logic [pDATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;

    logic                    push;
    logic                    pop;

    // Ready is decoded from registered state only, so it never forms a
    // combinational path back to fir_valid or sm_tready.
    assign fir_ready = (state == RUN) && (count < DEPTH_C) && (in_cnt < len);
    assign push      = fir_valid && fir_ready;

    assign sm_tvalid = (count != '0);
    assign sm_tdata  = sm_tvalid ? mem[rd_ptr] : '0;
    // count != 0 only inside RUN, where len != 0, so len-1 never wraps here.
    assign sm_tlast  = sm_tvalid && (out_cnt == (len - LEN_ONE));
    assign pop       = sm_tvalid && sm_tready;

    assign ap_done   = (state == DONE);
    assign out_busy  = (state != IDLE);

    // Control state machine, transfer length and sample counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            len     <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        len     <= data_length;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        // A zero-length transfer skips RUN entirely.
                        state   <= (data_length != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (push) in_cnt  <= in_cnt + LEN_ONE;
                    if (pop)  out_cnt <= out_cnt + LEN_ONE;
                    if (pop && sm_tlast) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the depth
    // is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fir_data;
    end

endmodule

// File: tb/tb_axis_out.sv
module tb_axis_out;

    localparam int DW = 32;
    localparam int LW = 32;
    localparam int FD = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          ap_start;
    logic [LW-1:0] data_length;
    logic [DW-1:0] fir_data;
    logic          fir_valid;
    logic          fir_ready;
    logic [DW-1:0] sm_tdata;
    logic          sm_tvalid;
    logic          sm_tlast;
    logic          sm_tready;
    logic          ap_done;
    logic          out_busy;

    always #5 clk = ~clk;

    axis_out #(
        .pDATA_WIDTH(DW),
        .pLEN_WIDTH (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ap_start   (ap_start),
        .data_length(data_length),
        .fir_data   (fir_data),
        .fir_valid  (fir_valid),
        .fir_ready  (fir_ready),
        .sm_tdata   (sm_tdata),
        .sm_tvalid  (sm_tvalid),
        .sm_tlast   (sm_tlast),
        .sm_tready  (sm_tready),
        .ap_done    (ap_done),
        .out_busy   (out_busy)
    );

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    int            pushed;
    int            popped;
    int            total;
    logic [DW-1:0] base;
    logic          done_seen;
    logic          stray_seen;

    typedef struct {
        logic          ap_start;
        logic [LW-1:0] len;
        logic [DW-1:0] data;
        logic          valid;
        logic          tready;
        logic          e_fir_ready;
        logic          e_tvalid;
        logic [DW-1:0] e_tdata;
        logic          e_tlast;
        logic          e_done;
        logic          e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [LW-1:0] len);
        ap_start    = 1'b1;
        data_length = len;
        fir_valid   = 1'b0;
        sm_tready   = 1'b0;
        tick();
        ap_start    = 1'b0;
        data_length = '0;
    endtask

    task automatic sb_reset(input int n, input logic [DW-1:0] first);
        exp_q.delete();
        pushed    = 0;
        popped    = 0;
        total     = n;
        base      = first;
        done_seen = 1'b0;
    endtask

    // One streaming cycle: offer the next sample, record accepted pushes,
    // check every pop against the expected queue.
    task automatic xfer_cycle(input logic rdy);
        logic [DW-1:0] e;
        sm_tready = rdy;
        fir_valid = (pushed < total);
        fir_data  = base + DW'(pushed);
        #1;
        if (fir_valid && fir_ready) begin
            exp_q.push_back(fir_data);
            pushed++;
        end
        if (sm_tvalid && sm_tready) begin
            if (exp_q.size() == 0) begin
                chk("pop_with_empty_model", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("stream_tdata", sm_tdata, e);
                chk("stream_tlast", 32'(sm_tlast), 32'(popped == total - 1));
                popped++;
            end
        end
        if (ap_done) done_seen = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic st, input logic [LW-1:0] len, input logic [DW-1:0] d,
                           input logic v, input logic r, input logic efr, input logic etv,
                           input logic [DW-1:0] etd, input logic etl, input logic edn,
                           input logic eby);
        vec_t x;
        x.ap_start = st;  x.len = len; x.data = d; x.valid = v; x.tready = r;
        x.e_fir_ready = efr; x.e_tvalid = etv; x.e_tdata = etd;
        x.e_tlast = etl; x.e_done = edn; x.e_busy = eby;
        vecs.push_back(x);
    endtask

    initial begin
        rst = 1'b1; ap_start = 1'b0; data_length = '0; fir_data = '0;
        fir_valid = 1'b0; sm_tready = 1'b0;

        // Per-cycle vectors: inputs held for that cycle, outputs expected in it.
        //        st len   data   v  r  fr tv tdata  tl dn by
        // basic stream, len=3
        add_vec(1, 3,    0,     0, 1, 0, 0, 0,     0, 0, 0);
        add_vec(0, 0,    'h11,  1, 1, 1, 0, 0,     0, 0, 1);
        add_vec(0, 0,    'h22,  1, 1, 1, 1, 'h11,  0, 0, 1);
        add_vec(0, 0,    'h33,  1, 1, 1, 1, 'h22,  0, 0, 1);
        add_vec(0, 0,    0,     0, 1, 0, 1, 'h33,  1, 0, 1);
        add_vec(0, 0,    0,     0, 1, 0, 0, 0,     0, 1, 1);
        add_vec(0, 0,    0,     0, 1, 0, 0, 0,     0, 0, 0);
        // zero length
        add_vec(1, 0,    0,     0, 1, 0, 0, 0,     0, 0, 0);
        add_vec(0, 0,    'h55,  1, 1, 0, 0, 0,     0, 1, 1);
        add_vec(0, 0,    'h55,  1, 1, 0, 0, 0,     0, 0, 0);
        // excess input and ignored restart, len=2
        add_vec(1, 2,    0,     0, 1, 0, 0, 0,     0, 0, 0);
        add_vec(1, 5,    'hA1,  1, 1, 1, 0, 0,     0, 0, 1);
        add_vec(0, 0,    'hA2,  1, 1, 1, 1, 'hA1,  0, 0, 1);
        add_vec(1, 5,    'hA3,  1, 1, 0, 1, 'hA2,  1, 0, 1);
        add_vec(0, 0,    'hA3,  1, 1, 0, 0, 0,     0, 1, 1);
        add_vec(0, 0,    'hA3,  1, 1, 0, 0, 0,     0, 0, 0);

        // reset state
        #1;
        chk("rst_fir_ready", 32'(fir_ready), 0);
        chk("rst_tvalid",    32'(sm_tvalid), 0);
        chk("rst_tdata",     sm_tdata,       0);
        chk("rst_done",      32'(ap_done),   0);
        chk("rst_busy",      32'(out_busy),  0);
        tick();
        tick();
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            ap_start    = vecs[i].ap_start;
            data_length = vecs[i].len;
            fir_data    = vecs[i].data;
            fir_valid   = vecs[i].valid;
            sm_tready   = vecs[i].tready;
            #1;
            chk($sformatf("vec%0d fir_ready", i), 32'(fir_ready), 32'(vecs[i].e_fir_ready));
            chk($sformatf("vec%0d tvalid", i),    32'(sm_tvalid), 32'(vecs[i].e_tvalid));
            chk($sformatf("vec%0d tdata", i),     sm_tdata,       vecs[i].e_tdata);
            chk($sformatf("vec%0d tlast", i),     32'(sm_tlast),  32'(vecs[i].e_tlast));
            chk($sformatf("vec%0d ap_done", i),   32'(ap_done),   32'(vecs[i].e_done));
            chk($sformatf("vec%0d busy", i),      32'(out_busy),  32'(vecs[i].e_busy));
            tick();
        end
        ap_start = 1'b0; fir_valid = 1'b0;

        // ---------------- backpressure, len=8 ----------------
        sb_reset(8, 32'h1);
        start(8);
        for (int i = 0; i < 6; i++) begin
            xfer_cycle(1'b0);
            if (i >= 4) chk("bp_hold_tdata", sm_tdata, 32'h1);
        end
        chk("bp_accepted",  32'(pushed),    32'd4);
        chk("bp_fir_ready", 32'(fir_ready), 0);
        chk("bp_tvalid",    32'(sm_tvalid), 1);
        chk("bp_tdata",     sm_tdata,       32'h1);
        chk("bp_tlast",     32'(sm_tlast),  0);

        // full FIFO with one simultaneous pop: no push that cycle
        xfer_cycle(1'b1);
        chk("fullpop_no_push",   32'(pushed),    32'd4);
        chk("fullpop_popped",    32'(popped),    32'd1);
        chk("fullpop_ready_next", 32'(fir_ready), 1);
        chk("fullpop_head",      sm_tdata,       32'h2);

        for (int i = 0; i < 40 && !done_seen; i++) xfer_cycle(1'b1);
        chk("bp_all_out",    32'(popped),    32'd8);
        chk("bp_done_seen",  32'(done_seen), 1);
        chk("bp_done_width", 32'(ap_done),   0);
        chk("bp_idle_busy",  32'(out_busy),  0);

        // ---------------- reset mid-transfer ----------------
        sb_reset(8, 32'h100);
        start(8);
        repeat (3) xfer_cycle(1'b0);
        chk("pre_rst_pushed", 32'(pushed),    32'd3);
        chk("pre_rst_tvalid", 32'(sm_tvalid), 1);
        fir_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_fir_ready", 32'(fir_ready), 0);
        chk("mid_rst_tvalid",    32'(sm_tvalid), 0);
        chk("mid_rst_tdata",     sm_tdata,       0);
        chk("mid_rst_tlast",     32'(sm_tlast),  0);
        chk("mid_rst_done",      32'(ap_done),   0);
        chk("mid_rst_busy",      32'(out_busy),  0);
        tick();
        rst = 1'b0;
        sm_tready  = 1'b1;
        stray_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ap_done || sm_tvalid || sm_tlast) stray_seen = 1'b1;
            tick();
        end
        chk("post_rst_quiet", 32'(stray_seen), 0);

        sb_reset(1, 32'hAB);
        start(1);
        for (int i = 0; i < 10 && !done_seen; i++) xfer_cycle(1'b1);
        chk("len1_popped",    32'(popped),    32'd1);
        chk("len1_done_seen", 32'(done_seen), 1);
        chk("len1_idle_busy", 32'(out_busy),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
